// File: rtl/pwm_dir_capture.sv
// PWM + direction capture: reports duty in percent and direction once per input period.
// Optional 3-sample majority glitch filter on pwm_in: define PWM_DIR_CAPTURE_FILTER_EN.
module pwm_dir_capture #(
  parameter int CLK_FREQUENCY  = 60_000_000,
  parameter int PWM_FREQUENCY  = 100_000,
  parameter int PERIOD_COUNT   = CLK_FREQUENCY / PWM_FREQUENCY,
  parameter int DUTY_1_PERCENT = PERIOD_COUNT / 100,
  parameter int TIMEOUT_COUNT  = 2 * PERIOD_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       pwm_in,
  input  logic       dir_in,
  output logic [6:0] duty_cycle,
  output logic       dir_out,
  output logic       valid,
  output logic       no_pulse
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam int CW = $clog2(TIMEOUT_COUNT + 1);
  localparam int SW = $clog2(DUTY_1_PERCENT + 1);

  logic          p_s1, p_s2, d_s1, d_s2, p_prev;
  logic          psync, dsync, rise, fall;
  logic [1:0]    state;
  logic [CW-1:0] period_cnt;
  logic [SW-1:0] sub_cnt;
  logic [6:0]    duty_amount;

`ifdef PWM_DIR_CAPTURE_FILTER_EN
  logic p_h0, p_h1, d_h0, d_h1;
  // p_prev doubles as the filter's held level: it is last cycle's filtered output
  assign psync = (p_s2 == p_h0 && p_h0 == p_h1) ? p_s2 : p_prev;
  assign dsync = d_h1;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_h0 <= 1'b0; p_h1 <= 1'b0; d_h0 <= 1'b0; d_h1 <= 1'b0;
    end else begin
      p_h0 <= p_s2; p_h1 <= p_h0; d_h0 <= d_s2; d_h1 <= d_h0;
    end
  end
`else
  assign psync = p_s2;
  assign dsync = d_s2;
`endif

  assign rise = psync & ~p_prev;
  assign fall = ~psync & p_prev;

  // Synchronisers and edge history run regardless of en so re-enable sees no false edge
  always_ff @(posedge clk) begin
    if (reset) begin
      p_s1 <= 1'b0; p_s2 <= 1'b0; d_s1 <= 1'b0; d_s2 <= 1'b0; p_prev <= 1'b0;
    end else begin
      p_s1 <= pwm_in; p_s2 <= p_s1; d_s1 <= dir_in; d_s2 <= d_s1; p_prev <= psync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      period_cnt  <= '0;
      sub_cnt     <= '0;
      duty_amount <= '0;
      duty_cycle  <= '0;
      dir_out     <= 1'b0;
      valid       <= 1'b0;
      no_pulse    <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state       <= IDLE;
        period_cnt  <= '0;
        sub_cnt     <= '0;
        duty_amount <= '0;
      end else if (rise) begin
        if (state == LOW) begin
          duty_cycle <= duty_amount;
          dir_out    <= dsync;
          valid      <= 1'b1;
          no_pulse   <= 1'b0;
        end
        state       <= HIGH;
        period_cnt  <= '0;
        sub_cnt     <= '0;
        duty_amount <= '0;
      end else if (period_cnt == CW'(TIMEOUT_COUNT - 1)) begin
        // Constant line: report the level, keep a high line armed for the next edge
        duty_cycle  <= psync ? 7'd100 : 7'd0;
        dir_out     <= dsync;
        valid       <= 1'b1;
        no_pulse    <= 1'b1;
        period_cnt  <= '0;
        sub_cnt     <= '0;
        duty_amount <= psync ? 7'd100 : 7'd0;
        state       <= psync ? HIGH : IDLE;
      end else begin
        period_cnt <= period_cnt + 1'b1;
        if (state == HIGH) begin
          if (sub_cnt == SW'(DUTY_1_PERCENT - 1)) begin
            sub_cnt <= '0;
            if (duty_amount < 7'd100) duty_amount <= duty_amount + 7'd1;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
          if (fall) state <= LOW;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_dir_capture.sv
// Randomised/directed bench for pwm_dir_capture against an edge-event reference model.
module tb_pwm_dir_capture;
  localparam int T    = 1200;
  localparam int D1   = 6;
  localparam int NMAX = 40000;
`ifdef PWM_DIR_CAPTURE_FILTER_EN
  localparam int DL = 4;
`else
  localparam int DL = 2;
`endif

  logic clk = 1'b0;
  logic reset, en, pwm_in, dir_in;
  logic [6:0] duty_cycle;
  logic dir_out, valid, no_pulse;

  pwm_dir_capture dut (
    .clk(clk), .reset(reset), .en(en), .pwm_in(pwm_in), .dir_in(dir_in),
    .duty_cycle(duty_cycle), .dir_out(dir_out), .valid(valid), .no_pulse(no_pulse)
  );

  always #5 clk = ~clk;

  bit pin_a [NMAX];
  bit din_a [NMAX];
  bit en_a  [NMAX];
  bit rst_a [NMAX];
  bit fl    [NMAX];
  int n = 1;
  int checks = 0, failures = 0;

  // model state
  int last_ref = 0, hl = 0;
  bit armed = 0;
  int e_duty = 0, e_dir = 0, e_np = 1, e_valid = 0;

  task automatic chk(input string tag, input int got, input int exp, input int cyc);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic add(input bit p, input bit d, input bit e, input bit r, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (n < NMAX) begin
        pin_a[n] = p; din_a[n] = d; en_a[n] = e; rst_a[n] = r; n++;
      end
    end
  endtask

  task automatic periods(input int period, input int high, input bit d, input int num);
    for (int i = 0; i < num; i++) begin
      add(1'b1, d, 1'b1, 1'b0, high);
      add(1'b0, d, 1'b1, 1'b0, period - high);
    end
  endtask

  function automatic bit pa(input int i);
    return (i < 0) ? 1'b0 : pin_a[i];
  endfunction

  function automatic bit da(input int i);
    return (i < 0) ? 1'b0 : din_a[i];
  endfunction

  // Reference: level seen by the capture logic before edge e, then the report rules
  task automatic model_step(input int e);
    bit f, fp, dv;
`ifdef PWM_DIR_CAPTURE_FILTER_EN
    if (pa(e-2) == pa(e-3) && pa(e-3) == pa(e-4)) f = pa(e-2);
    else f = fl[e-1];
`else
    f = pa(e-2);
`endif
    fl[e] = f;
    fp = fl[e-1];
    dv = da(e-DL);
    e_valid = 0;
    if (rst_a[e]) begin
      e_duty = 0; e_dir = 0; e_np = 1; armed = 0; last_ref = e; hl = 0;
    end else if (!en_a[e]) begin
      armed = 0; last_ref = e; hl = 0;
    end else if (f && !fp) begin
      if (armed) begin
        e_valid = 1; e_duty = (hl / D1 > 100) ? 100 : hl / D1; e_dir = dv; e_np = 0;
      end
      armed = 1; hl = 0; last_ref = e;
    end else if (e - last_ref == T) begin
      e_valid = 1; e_duty = f ? 100 : 0; e_dir = dv; e_np = 1;
      armed = f; hl = T; last_ref = e;
    end else if (fp) begin
      hl++;
    end
  endtask

  initial begin
    int per, hi;
    fl[0] = 1'b0;
    add(1'b0, 1'b0, 1'b1, 1'b1, 4);
    add(1'b0, 1'b0, 1'b1, 1'b0, 10);
    periods(600, 300, 1'b1, 5);
    periods(600, 6, 1'b0, 3);
    periods(600, 11, 1'b1, 3);
    periods(600, 599, 1'b0, 3);
    periods(720, 700, 1'b1, 3);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2500);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2500);
    periods(600, 150, 1'b1, 2);
    add(1'b1, 1'b1, 1'b1, 1'b0, 150);
    add(1'b0, 1'b1, 1'b1, 1'b0, 200);
    add(1'b0, 1'b1, 1'b0, 1'b0, 50);
    add(1'b0, 1'b1, 1'b1, 1'b0, 200);
    periods(600, 150, 1'b0, 3);
    add(1'b1, 1'b0, 1'b1, 1'b0, 300);
    add(1'b0, 1'b0, 1'b1, 1'b0, 100);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3);
    add(1'b0, 1'b0, 1'b1, 1'b0, 197);
    periods(600, 300, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      add(1'b1, 1'b1, 1'b1, 1'b0, 150);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1);
      add(1'b1, 1'b1, 1'b1, 1'b0, 149);
      add(1'b0, 1'b1, 1'b1, 1'b0, 300);
    end
    for (int i = 0; i < 10; i++) begin
      per = $urandom_range(1100, 100);
      hi  = $urandom_range(per - 1, 1);
      periods(per, hi, 1'($urandom_range(1, 0)), 2);
    end
    add(1'b0, 1'b0, 1'b1, 1'b0, 20);

    reset = 1'b1; en = 1'b1; pwm_in = 1'b0; dir_in = 1'b0;
    for (int e = 1; e < n; e++) begin
      @(negedge clk);
      pwm_in = pin_a[e]; dir_in = din_a[e]; en = en_a[e]; reset = rst_a[e];
      @(posedge clk);
      #1;
      model_step(e);
      chk("valid", int'(valid), e_valid, e);
      chk("duty", int'(duty_cycle), e_duty, e);
      chk("dir", int'(dir_out), e_dir, e);
      chk("no_pulse", int'(no_pulse), e_np, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_dir_capture.md
Name: pwm_dir_capture

Overview:
- Receive-side counterpart of the motor PWM/direction generator. Measures an incoming PWM + direction pair and reports the duty cycle as an integer percent (0-100) plus the direction bit, once per PWM period.
- Uses: loopback self-test of motor outputs; reading PWM commands from an external controller onto the peripheral bus.

Parameters:
- CLK_FREQUENCY, 60_000_000, system clock in Hz.
- PWM_FREQUENCY, 100_000, nominal input PWM frequency in Hz.
- PERIOD_COUNT, CLK_FREQUENCY/PWM_FREQUENCY, clocks per nominal period (600).
- DUTY_1_PERCENT, PERIOD_COUNT/100, clocks per 1 % of duty (6).
- TIMEOUT_COUNT, 2*PERIOD_COUNT, clocks without a rising edge before a constant-level report (1200).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; low holds the block idle.
- pwm_in  input  1  asynchronous PWM input.
- dir_in  input  1  asynchronous direction input.
- duty_cycle  output  7  last measured duty in percent, 0..100.
- dir_out  output  1  direction sampled at the last report.
- valid  output  1  one-cycle strobe when duty_cycle/dir_out update.
- no_pulse  output  1  1 = last report came from timeout (constant level), 0 = from a measured period.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Synchronisation: pwm_in and dir_in each pass through a 2-FF synchroniser. Rising/falling edges are detected on the synchronised pwm (psync vs. its previous value).
- Reset values: duty_cycle=0, dir_out=0, valid=0, no_pulse=1. All counters are 0 and the FSM is in IDLE.
- FSM states are IDLE, HIGH, LOW.
  - IDLE: waits for a rising edge, then goes to HIGH. Counters are cleared.
  - HIGH: per-clock sub-counter runs 0..DUTY_1_PERCENT-1. On wrap it increments duty_amount, which saturates at 100. A falling edge moves the FSM to LOW.
  - LOW: counting stops. A rising edge triggers a publish: duty_cycle<=duty_amount, dir_out<=dir sync, valid=1, no_pulse<=0. Counters clear and the FSM goes to HIGH, starting the new period on the same cycle.
- Period counter:
  - Counts every clock while not in IDLE.
  - Also counts in IDLE, so a stuck line is still reported.
  - Clears on every rising edge.
- Duty arithmetic: result is floor(high_clocks/DUTY_1_PERCENT), clamped to 100. High time of 0 clocks is impossible from a measured period.
- Timeout: when the period counter reaches TIMEOUT_COUNT-1 with no rising edge:
  - Publish duty_cycle<=100 if psync=1, else 0; dir_out<=dir sync; valid=1; no_pulse<=1.
  - Period counter restarts. FSM goes to IDLE if psync=0, or HIGH with duty_amount forced to 100 if psync=1.
  - Repeats every TIMEOUT_COUNT clocks while the line stays constant.
- Simultaneous rising edge and timeout on the same cycle: the edge wins (measured publish, no_pulse=0).
- Latency: valid asserts 3 clocks after the pwm_in rising edge (2 synchroniser + 1 register).
- en=0:
  - FSM goes to IDLE and counters clear. valid=0.
  - duty_cycle, dir_out and no_pulse hold their last values.
  - The synchronisers keep running, so capture restarts cleanly on en=1.
- Reset mid-period: all state returns to reset values on the next clock. No partial report is published.
- Counter widths are $clog2-sized to hold TIMEOUT_COUNT and 100. The period counter must not wrap before TIMEOUT_COUNT.

Optional Feature:
- Macro: PWM_DIR_CAPTURE_FILTER_EN.
- Defined: a 3-sample majority filter follows the pwm_in synchroniser.
  - The filtered level changes only when the last 3 synchronised samples agree.
  - Rejects 1-2 clock glitches.
  - Adds 2 clocks latency, so valid arrives 5 clocks after the edge.
  - dir_in gets a matching 2-stage delay to stay aligned.
- Undefined: no filter; latency is 3 clocks; single-clock glitches are counted as edges.

Test Plan:
- 600-clock period, 300 clocks high, dir_in=1 -> valid every 600 clocks, duty_cycle=50, dir_out=1, no_pulse=0; first valid 3 clocks after the second rising edge.
- High times of 6, 11, 599 clocks per 600-clock period -> duty_cycle = 1, 1, 99.
- 700 clocks high in a 720-clock period -> duty_cycle saturates at 100.
- pwm_in held high for 2500 clocks -> valid at 1200 and 2400 clocks, duty_cycle=100, no_pulse=1. Held low -> same timing, duty_cycle=0.
- Drop en mid-period for 50 clocks, then resume a 25 % waveform -> no valid while en=0 and the previous outputs hold. First report after re-enable is 25, only after a full observed period.
- With PWM_DIR_CAPTURE_FILTER_EN, inject a 1-clock low glitch inside a 50 % high phase -> duty_cycle=50 and valid at edge+5. Without the macro -> short duty report (glitch counted as an edge).
